// File: rtl/ex_issue_arbiter.sv
// Picks one of the per-FU issue queues per cycle (round-robin, starvation override, CSR serialised behind an empty ROB).
// Latency 1 to issue_*; grant is the combinational pop, busy FUs are skipped and CSR stalls all grants until csr_done.
module ex_issue_arbiter #(
   parameter int FU_NUMBER      = 4,
   parameter int ROB_INDEX_BITS = 3,
   parameter int STARVE_LIMIT   = 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [FU_NUMBER-1:0]                req_valid,
   input  logic [FU_NUMBER*ROB_INDEX_BITS-1:0] req_ticket,
   input  logic [1:0]                          fu_busy,
   input  logic                                rob_empty,
   input  logic                                csr_done,
   input  logic                                flush,
   output logic [FU_NUMBER-1:0]                grant,
   output logic                                issue_valid,
   output logic [1:0]                          issue_fu,
   output logic [ROB_INDEX_BITS-1:0]           issue_ticket,
   output logic [1:0]                          state_o
);
   localparam int            PW      = $clog2(FU_NUMBER);
   localparam logic [PW-1:0] CSR_IDX = PW'(1);
   localparam logic [3:0]    AGE_LIM = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, CSR_WAIT = 2'd2} state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_live;
   logic [PW-1:0]        r_rr_ptr;
   logic [3:0]           r_age [FU_NUMBER];
   logic [FU_NUMBER-1:0] w_blocked;
   logic [FU_NUMBER-1:0] w_elig;
   logic                 w_sel_vld;
   logic [PW-1:0]        w_sel_idx;
   logic                 w_gnt_vld;
   logic [PW-1:0]        w_gnt_idx;

   // CSR is never "blocked" here: its gating lives in the FSM
   always_comb begin
      w_blocked    = '0;
      w_blocked[0] = fu_busy[0];
      w_blocked[2] = fu_busy[1];
   end

   assign w_elig = req_valid & ~w_blocked;

   always_comb begin
      logic [PW-1:0] v_idx;
      v_idx     = '0;
      w_sel_vld = 1'b0;
      w_sel_idx = '0;
      // descending scan so the closest-to-pointer eligible queue is written last
      for (int k = FU_NUMBER - 1; k >= 0; k--) begin
         v_idx = r_rr_ptr + PW'(k);
         if (w_elig[v_idx]) begin
            w_sel_vld = 1'b1;
            w_sel_idx = v_idx;
         end
      end
      for (int i = FU_NUMBER - 1; i >= 0; i--) begin
         if (w_elig[i] && (r_age[i] >= AGE_LIM)) begin
            w_sel_vld = 1'b1;
            w_sel_idx = PW'(i);
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_gnt_vld   = 1'b0;
      w_gnt_idx   = w_sel_idx;
      unique case (r_state)
         RUN: begin
            if (w_sel_vld) begin
               if (w_sel_idx == CSR_IDX) begin
                  if (rob_empty) begin
                     w_gnt_vld   = 1'b1;
                     w_state_nxt = CSR_WAIT;
                  end else begin
                     w_state_nxt = DRAIN;
                  end
               end else begin
                  w_gnt_vld = 1'b1;
               end
            end
         end
         DRAIN: begin
            if (rob_empty && req_valid[CSR_IDX]) begin
               w_gnt_vld   = 1'b1;
               w_gnt_idx   = CSR_IDX;
               w_state_nxt = CSR_WAIT;
            end else if (!req_valid[CSR_IDX]) begin
               w_state_nxt = RUN;
            end
         end
         CSR_WAIT: begin
            if (csr_done) w_state_nxt = RUN;
         end
         default: w_state_nxt = RUN;
      endcase
      // the first edge after reset release is an idle cycle
      if (!r_live) begin
         w_gnt_vld   = 1'b0;
         w_state_nxt = r_state;
      end
      if (flush) begin
         w_gnt_vld   = 1'b0;
         w_state_nxt = RUN;
      end
   end

   always_comb begin
      grant = '0;
      if (w_gnt_vld) grant[w_gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= RUN;
         r_live   <= 1'b0;
         r_rr_ptr <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_live  <= 1'b1;
         if (w_gnt_vld) r_rr_ptr <= w_gnt_idx + PW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FU_NUMBER; i++) r_age[i] <= '0;
      end else if (flush) begin
         for (int i = 0; i < FU_NUMBER; i++) r_age[i] <= '0;
      end else if (r_live && (r_state == RUN)) begin
         for (int i = 0; i < FU_NUMBER; i++) begin
            if (!w_elig[i] || grant[i]) r_age[i] <= '0;
            else if (r_age[i] != 4'hF)  r_age[i] <= r_age[i] + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_valid  <= 1'b0;
         issue_fu     <= '0;
         issue_ticket <= '0;
      end else begin
         issue_valid <= w_gnt_vld;
         if (w_gnt_vld) begin
            issue_fu     <= 2'(w_gnt_idx);
            issue_ticket <= req_ticket[w_gnt_idx*ROB_INDEX_BITS +: ROB_INDEX_BITS];
         end
      end
   end

   assign state_o = r_state;

endmodule
